uart_rx_cfg: RTL and testbench

Parametrised UART receiver that replaces the fixed 8-data-bit, odd/even-only receiver in the UART client path. Data width, parity mode, stop-bit count and oversample rate are configurable. It adds false-start rejection, mid-bit majority sampling, framing and break detection, and a valid/ready output register with overrun reporting. It sits between the pad-side rxd line and the client's byte consumer, and is driven by the shared baud-tick generator.

---
 rtl/uart_rx_cfg.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised and majority-filtered line, mid-bit voting,
// parity/framing/break detection and a valid/ready output register with overrun pulse.
module uart_rx_cfg #(
    parameter int OVERSAMPLE_RATE = 16,
    parameter int DATA_BITS       = 8,
    parameter int PARITY_MODE     = 2,
    parameter int STOP_BITS       = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tick_i,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 overrun_o,
    output logic                 busy_o,
    output logic [2:0]           fsm_state_o
);

    localparam int TW = $clog2(OVERSAMPLE_RATE);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TICK_MID   = TW'(OVERSAMPLE_RATE / 2);
    localparam logic [TW-1:0] TICK_VOTE  = TW'(OVERSAMPLE_RATE / 2 + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE_RATE - 1);
    localparam logic [IW-1:0] BIT_LAST   = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST  = (STOP_BITS == 2);
    localparam logic          HAS_PARITY = (PARITY_MODE != 0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_DONE      = 3'd5,
        ST_WAIT_HIGH = 3'd6
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t               state, state_n;
    logic [1:0]           sync_q;
    logic [2:0]           filt_q;
    logic                 line_s;
    logic [TW-1:0]        tcnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [1:0]           samp;
    logic                 par_bit;
    logic                 stop_idx;
    logic                 stop_err;
    logic                 stop_all0;
    logic                 stop_last;

    logic                 at_mid;
    logic                 at_vote;
    logic                 at_wrap;
    logic                 bit_val;
    logic                 exp_par;
    logic                 par_err;
    logic                 brk;

    // Line conditioning: 2-FF synchroniser, then a 3-deep majority filter; idle level is 1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
            filt_q <= 3'b111;
            line_s <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value of its neighbour.
            sync_q <= {sync_q[0], rxd_i};
            filt_q <= {filt_q[1:0], sync_q[1]};
            line_s <= maj3(filt_q[0], filt_q[1], filt_q[2]);
        end
    end

    assign at_mid  = tick_i && (tcnt == TICK_MID);
    assign at_vote = tick_i && (tcnt == TICK_VOTE);
    assign at_wrap = tick_i && (tcnt == TICK_LAST);
    // samp holds the line at ticks S-1 and S; the current line_s is tick S+1.
    assign bit_val = maj3(samp[1], samp[0], line_s);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_n and no latch is inferred.
        state_n = state;
        case (state)
            ST_IDLE:
                if (tick_i && !line_s) state_n = ST_START;
            ST_START:
                if (at_mid && line_s) state_n = ST_IDLE;
                else if (at_wrap)     state_n = ST_DATA;
            ST_DATA:
                if (at_wrap && bit_idx == BIT_LAST)
                    state_n = HAS_PARITY ? ST_PARITY : ST_STOP;
            ST_PARITY:
                if (at_wrap) state_n = ST_STOP;
            ST_STOP:
                if (at_vote && stop_idx == STOP_LAST) state_n = ST_DONE;
            ST_DONE:
                state_n = stop_last ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH:
                if (tick_i && line_s) state_n = ST_IDLE;
            default:
                state_n = ST_IDLE;
        endcase
    end

    // Bit timing, voting and per-frame accumulation; ticks are ignored while in DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tcnt      <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            samp      <= '0;
            par_bit   <= 1'b0;
            stop_idx  <= 1'b0;
            stop_err  <= 1'b0;
            stop_all0 <= 1'b0;
            stop_last <= 1'b0;
        end else begin
            if (tick_i && state != ST_DONE) samp <= {samp[0], line_s};

            case (state)
                ST_IDLE: begin
                    tcnt      <= (tick_i && !line_s) ? TW'(1) : '0;
                    bit_idx   <= '0;
                    stop_idx  <= 1'b0;
                    stop_err  <= 1'b0;
                    stop_all0 <= 1'b1;
                end
                ST_DONE, ST_WAIT_HIGH: begin
                    tcnt <= '0;
                end
                default: begin
                    if (tick_i) tcnt <= tcnt + TW'(1);
                end
            endcase

            if (state == ST_DATA && at_vote) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            if (state == ST_DATA && at_wrap) bit_idx <= bit_idx + IW'(1);
            if (state == ST_PARITY && at_vote) par_bit <= bit_val;

            if (state == ST_STOP && at_vote) begin
                stop_err  <= stop_err | ~bit_val;
                stop_all0 <= stop_all0 & ~bit_val;
                stop_last <= bit_val;
            end
            // Only a first-of-two stop bit reaches its wrap; the last one exits at its vote tick.
            if (state == ST_STOP && at_wrap) stop_idx <= 1'b1;
        end
    end

    always_comb begin
        exp_par = 1'b0;
        case (PARITY_MODE)
            1:       exp_par = ^shreg;
            2:       exp_par = ~(^shreg);
            3:       exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
    end

    assign par_err = HAS_PARITY && (par_bit != exp_par);
    assign brk     = (shreg == '0) && (!HAS_PARITY || !par_bit) && stop_all0;

    // Output register: a held, unaccepted frame is never overwritten.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            break_o      <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (state == ST_DONE) begin
                if (!valid_o || ready_i) begin
                    data_o       <= shreg;
                    valid_o      <= 1'b1;
                    parity_err_o <= par_err;
                    frame_err_o  <= stop_err;
                    break_o      <= brk;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

    assign busy_o      = (state != ST_IDLE);
    assign fsm_state_o = state;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four configurations (8N1, 8O1, 7E2, 8E1) on private rxd lines,
// a directed frame table, multi-cycle corner sequences and random frames against a frame model.
module tb_uart_rx_cfg;

    localparam int OSR  = 16;
    localparam int NDUT = 4;

    function automatic int cfg_db(input int i);
        return (i == 2) ? 7 : 8;
    endfunction
    function automatic int cfg_pm(input int i);
        case (i)
            0:       return 0;
            1:       return 2;
            default: return 1;
        endcase
    endfunction
    function automatic int cfg_sb(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    logic            clk = 1'b0;
    logic            rst;
    logic            tick;
    logic [NDUT-1:0] rxd, ready, valid, perr, ferr, brk, ovr, busy;
    logic [8:0]      data [NDUT];
    logic [2:0]      st   [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [cfg_db(g)-1:0] d;
        uart_rx_cfg #(
            .OVERSAMPLE_RATE(OSR),
            .DATA_BITS      (cfg_db(g)),
            .PARITY_MODE    (cfg_pm(g)),
            .STOP_BITS      (cfg_sb(g))
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .tick_i      (tick),
            .rxd_i       (rxd[g]),
            .data_o      (d),
            .valid_o     (valid[g]),
            .ready_i     (ready[g]),
            .parity_err_o(perr[g]),
            .frame_err_o (ferr[g]),
            .break_o     (brk[g]),
            .overrun_o   (ovr[g]),
            .busy_o      (busy[g]),
            .fsm_state_o (st[g])
        );
        assign data[g] = 9'(d);
    end

    // One-cycle tick every 4 clocks, changed just after the rising edge.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    typedef struct packed {
        logic [8:0] d;
        logic       p;
        logic       f;
        logic       b;
    } exp_t;

    typedef struct packed {
        logic [1:0] idx;
        logic [8:0] d;
        logic       p;
        logic       f;
        logic       b;
    } cap_t;

    typedef struct {
        int         idx;
        logic [8:0] d;
        logic       pbit;
        logic [1:0] stops;
        exp_t       e;
    } vec_t;

    cap_t cap_q[$];
    int   rd_ptr     = 0;
    int   ov_cnt [NDUT] = '{default: 0};
    int   low0_cnt   = 0;
    int   busy_ticks = 0;
    int   vec_cnt    = 0;
    int   err_cnt    = 0;

    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (valid[i] && ready[i]) cap_q.push_back('{2'(i), data[i], perr[i], ferr[i], brk[i]});
            if (ovr[i]) ov_cnt[i]++;
        end
        if (!valid[0]) low0_cnt++;
        if (tick && busy[0]) busy_ticks++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (tick !== 1'b1);
        #1;
    endtask

    task automatic drive_bit(input int idx, input logic v);
        rxd[idx] = v;
        repeat (OSR) wait_tick();
    endtask

    task automatic send_frame(input int idx, input logic [8:0] d, input logic pbit,
                              input logic [1:0] stops, input int idle_bits);
        drive_bit(idx, 1'b0);
        for (int i = 0; i < cfg_db(idx); i++) drive_bit(idx, d[i]);
        if (cfg_pm(idx) != 0) drive_bit(idx, pbit);
        for (int i = 0; i < cfg_sb(idx); i++) drive_bit(idx, stops[i]);
        for (int i = 0; i < idle_bits; i++) drive_bit(idx, 1'b1);
    endtask

    // Reference: the parity bit a correct transmitter would send for this mode.
    function automatic logic par_of(input int idx, input logic [8:0] d);
        int ones = $countones(d);
        case (cfg_pm(idx))
            1:       return (ones % 2) == 1;
            2:       return (ones % 2) == 0;
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model(input int idx, input logic [8:0] d, input logic pbit,
                                   input logic [1:0] stops);
        exp_t       e;
        logic [8:0] dm    = d & 9'((1 << cfg_db(idx)) - 1);
        logic       has_p = cfg_pm(idx) != 0;
        logic       any0  = (cfg_sb(idx) == 1) ? !stops[0] : (stops != 2'b11);
        logic       all0  = (cfg_sb(idx) == 1) ? !stops[0] : (stops == 2'b00);
        e.d = dm;
        e.p = has_p && (pbit != par_of(idx, dm));
        e.f = any0;
        e.b = (dm == 9'd0) && (!has_p || !pbit) && all0;
        return e;
    endfunction

    task automatic expect_frame(input string name, input int idx, input exp_t e);
        cap_t c;
        check({name, "_count"}, cap_q.size() - rd_ptr, 1);
        if (cap_q.size() > rd_ptr) begin
            c      = cap_q[rd_ptr];
            rd_ptr = cap_q.size();
            check({name, "_dut"},   c.idx, idx);
            check({name, "_data"},  c.d,   e.d);
            check({name, "_perr"},  c.p,   e.p);
            check({name, "_ferr"},  c.f,   e.f);
            check({name, "_break"}, c.b,   e.b);
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    vec_t tbl [9];

    initial begin
        int   ov0, low0, bt0, k;
        exp_t e;

        tbl[0] = '{0, 9'h055, 1'b0, 2'b11, '{9'h055, 1'b0, 1'b0, 1'b0}};
        tbl[1] = '{1, 9'h0A7, 1'b1, 2'b11, '{9'h0A7, 1'b1, 1'b0, 1'b0}};
        tbl[2] = '{1, 9'h0A7, 1'b0, 2'b11, '{9'h0A7, 1'b0, 1'b0, 1'b0}};
        tbl[3] = '{2, 9'h03C, 1'b0, 2'b01, '{9'h03C, 1'b0, 1'b1, 1'b0}};
        tbl[4] = '{2, 9'h03C, 1'b0, 2'b10, '{9'h03C, 1'b0, 1'b1, 1'b0}};
        tbl[5] = '{3, 9'h000, 1'b0, 2'b11, '{9'h000, 1'b0, 1'b0, 1'b0}};
        tbl[6] = '{0, 9'h000, 1'b0, 2'b10, '{9'h000, 1'b0, 1'b1, 1'b1}};
        tbl[7] = '{1, 9'h0FF, 1'b1, 2'b11, '{9'h0FF, 1'b0, 1'b0, 1'b0}};
        tbl[8] = '{2, 9'h07F, 1'b0, 2'b11, '{9'h07F, 1'b1, 1'b0, 1'b0}};

        rst   = 1'b1;
        rxd   = '1;
        ready = '1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        check("rst_valid",   valid, '0);
        check("rst_busy",    busy,  '0);
        check("rst_perr",    perr,  '0);
        check("rst_ferr",    ferr,  '0);
        check("rst_break",   brk,   '0);
        check("rst_overrun", ovr,   '0);
        check("rst_data0",   data[0], 0);
        check("rst_state0",  st[0],   0);
        repeat (OSR) wait_tick();

        for (int t = 0; t < 9; t++) begin
            send_frame(tbl[t].idx, tbl[t].d, tbl[t].pbit, tbl[t].stops, 2);
            expect_frame($sformatf("tbl%0d", t), tbl[t].idx, tbl[t].e);
        end

        // Four-tick low glitch: start is rejected at the mid tick of the start bit.
        bt0 = busy_ticks;
        rxd[0] = 1'b0;
        repeat (4) wait_tick();
        rxd[0] = 1'b1;
        repeat (2 * OSR) wait_tick();
        check("glitch_busy_ticks", busy_ticks - bt0, OSR / 2);
        check("glitch_busy",       busy[0], 0);
        check("glitch_valid",      valid[0], 0);
        check("glitch_nocap",      cap_q.size() - rd_ptr, 0);

        // 8E1 line held low for 20 bit times: one break frame, then wait for high.
        rxd[3] = 1'b0;
        repeat (15 * OSR) wait_tick();
        check("break_wait_high_state", st[3], 6);
        repeat (5 * OSR) wait_tick();
        rxd[3] = 1'b1;
        repeat (2 * OSR) wait_tick();
        expect_frame("break", 3, '{9'h000, 1'b0, 1'b1, 1'b1});
        check("break_idle_state", st[3], 0);
        send_frame(3, 9'h081, 1'b0, 2'b11, 2);
        expect_frame("after_break", 3, '{9'h081, 1'b0, 1'b0, 1'b0});

        // Overrun: second frame dropped while the first is held.
        ready[0] = 1'b0;
        ov0 = ov_cnt[0];
        send_frame(0, 9'h012, 1'b0, 2'b11, 2);
        check("ovr_first_valid", valid[0], 1);
        check("ovr_first_data",  data[0],  9'h012);
        send_frame(0, 9'h034, 1'b0, 2'b11, 2);
        check("ovr_pulses",  ov_cnt[0] - ov0, 1);
        check("ovr_valid",   valid[0], 1);
        check("ovr_data",    data[0],  9'h012);
        check("ovr_nocap",   cap_q.size() - rd_ptr, 0);
        ready[0] = 1'b1;
        @(posedge clk);
        #1 ready[0] = 1'b0;
        @(negedge clk);
        check("ovr_drained_valid", valid[0], 0);
        expect_frame("ovr_drain", 0, '{9'h012, 1'b0, 1'b0, 1'b0});

        // Accept-and-load: ready raised only for the DONE cycle of the second frame.
        send_frame(0, 9'h012, 1'b0, 2'b11, 2);
        ov0  = ov_cnt[0];
        low0 = low0_cnt;
        k    = 0;
        fork
            send_frame(0, 9'h034, 1'b0, 2'b11, 2);
            begin
                do begin
                    @(posedge clk);
                    #1 k++;
                end while (st[0] != 3'd5 && k < 2000);
                check("acc_reached_done", st[0], 5);
                ready[0] = 1'b1;
                @(posedge clk);
                #1 ready[0] = 1'b0;
            end
        join
        check("acc_valid_continuous", low0_cnt - low0, 0);
        check("acc_no_overrun",       ov_cnt[0] - ov0, 0);
        check("acc_data",             data[0], 9'h034);
        expect_frame("acc_old", 0, '{9'h012, 1'b0, 1'b0, 1'b0});
        ready[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_frame("acc_new", 0, '{9'h034, 1'b0, 1'b0, 1'b0});

        // Reset asserted in the middle of the data bits of a 0xFF frame.
        fork
            send_frame(0, 9'h0FF, 1'b0, 2'b11, 2);
            begin
                repeat (4 * OSR) wait_tick();
                check("rst_mid_state", st[0], 2);
                rst = 1'b1;
            end
        join
        rst = 1'b0;
        repeat (OSR) wait_tick();
        check("rst_mid_nocap", cap_q.size() - rd_ptr, 0);
        check("rst_mid_valid", valid[0], 0);
        check("rst_mid_busy",  busy[0],  0);
        send_frame(0, 9'h05A, 1'b0, 2'b11, 2);
        expect_frame("after_rst", 0, '{9'h05A, 1'b0, 1'b0, 1'b0});

        // Random frames on every configuration, checked against the frame model.
        for (int idx = 0; idx < NDUT; idx++) begin
            for (int n = 0; n < 6; n++) begin
                logic [8:0] d;
                logic       pbit;
                logic [1:0] stops;
                d     = 9'($urandom_range(1, (1 << cfg_db(idx)) - 1));
                pbit  = par_of(idx, d) ^ ($urandom_range(0, 3) == 0);
                stops = 2'b11;
                if ($urandom_range(0, 3) == 0) stops = 2'($urandom_range(0, 2));
                e = model(idx, d, pbit, stops);
                send_frame(idx, d, pbit, stops, 2);
                expect_frame($sformatf("rnd_d%0d_n%0d", idx, n), idx, e);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
